// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute / CDB broadcast stage: op codes,
// the bubble marker and the result-queue geometry.
package alu_pkg;

    // ALU control encoding carried in instrInfo. Values 11..14 are reserved
    // and are treated exactly like a bubble.
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_PASS2  = 4'd10,
        ALU_BUBBLE = 4'b1111
    } alu_op_e;

    // Result queue: two entries so that the instruction already latched by
    // the reservation station always has somewhere to land.
    localparam int QUEUE_DEPTH = 2;
    localparam int QUEUE_PTR_W = $clog2(QUEUE_DEPTH);
    localparam int QUEUE_CNT_W = $clog2(QUEUE_DEPTH + 1);

    // True for every op that produces a result worth broadcasting.
    function automatic logic op_is_valid(input logic [3:0] op);
        return op <= ALU_PASS2;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Two-entry FIFO of {result, ROB tag} waiting for the common data bus.
// Owns the flush behaviour and the sticky overflow flag.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [DW-1:0]          push_value,
    input  logic [RW-1:0]          push_rob,
    input  logic                   pop_req,
    output logic [DW-1:0]          head_value,
    output logic [RW-1:0]          head_rob,
    output logic [QUEUE_CNT_W-1:0] count,
    output logic                   overflow
);

    typedef struct packed {
        logic [DW-1:0] value;
        logic [RW-1:0] rob;
    } entry_t;

    entry_t                 mem_reg [QUEUE_DEPTH];
    logic [QUEUE_PTR_W-1:0] rd_ptr_reg;
    logic [QUEUE_PTR_W-1:0] wr_ptr_reg;
    logic [QUEUE_CNT_W-1:0] count_reg;
    logic                   overflow_reg;

    logic   not_empty;
    logic   full;
    logic   do_pop;
    logic   do_push;
    entry_t head;

    assign not_empty = (count_reg != '0);
    assign full      = (count_reg == QUEUE_CNT_W'(QUEUE_DEPTH));
    // A grant against an empty queue is meaningless and ignored.
    assign do_pop    = pop_req & not_empty & ~flush;
    // When full, a simultaneous pop frees the slot the push needs.
    assign do_push   = push & ~flush & (~full | do_pop);

    // Entry storage: written at the tail on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (do_push) begin
            mem_reg[wr_ptr_reg] <= '{value: push_value, rob: push_rob};
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + QUEUE_PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + QUEUE_PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + QUEUE_CNT_W'(1);
                2'b01:   count_reg <= count_reg - QUEUE_CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Sticky error: a result arrived with nowhere to go and was dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (push & ~flush & full & ~do_pop) begin
            overflow_reg <= 1'b1;
        end
    end

    assign head       = mem_reg[rd_ptr_reg];
    assign head_value = not_empty ? head.value : '0;
    assign head_rob   = not_empty ? head.rob   : '0;
    assign count      = count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: rtl/alu_cdb_writer.sv
// ALU execute stage: computes the result of the issued bundle, queues it and
// presents the queue head to the CDB arbiter. Also throttles issue via aluFree.
module alu_cdb_writer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 31,
    parameter int ROB     = 2,
    parameter int C_WIDTH = 3
) (
    input  logic                clk,
    input  logic                globalResetN,
    input  logic signed [WIDTH:0] src1,
    input  logic signed [WIDTH:0] src2,
    input  logic [C_WIDTH:0]    instrInfo,
    input  logic [ROB:0]        instrRob,
    input  logic                clear,
    input  logic                validCommit,
    input  logic                cdbGrant,
    output logic                cdbRequest,
    output logic [WIDTH:0]      cdbValue,
    output logic [ROB:0]        cdbRob,
    output logic                aluFree,
    output logic                overflow
);

    logic [3:0]             op;
    logic [4:0]             shamt;
    logic [WIDTH:0]         result;
    logic                   flush;
    logic                   push;
    logic [QUEUE_CNT_W-1:0] count;

    assign op    = 4'(instrInfo);
    assign shamt = src2[4:0];
    assign flush = clear & validCommit;
    assign push  = op_is_valid(op) & ~flush;

    // Combinational ALU; bubble and reserved ops yield zero and are never pushed.
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = src1 + src2;
            ALU_SUB:   result = src1 - src2;
            ALU_AND:   result = src1 & src2;
            ALU_OR:    result = src1 | src2;
            ALU_XOR:   result = src1 ^ src2;
            ALU_SLL:   result = src1 << shamt;
            ALU_SRL:   result = $unsigned(src1) >> shamt;
            ALU_SRA:   result = $unsigned(src1 >>> shamt);
            ALU_SLT:   result[0] = (src1 < src2);
            ALU_SLTU:  result[0] = ($unsigned(src1) < $unsigned(src2));
            ALU_PASS2: result = src2;
            default:   result = '0;
        endcase
    end

    alu_result_fifo #(
        .DW (WIDTH + 1),
        .RW (ROB + 1)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (globalResetN),
        .flush      (flush),
        .push       (push),
        .push_value (result),
        .push_rob   (instrRob),
        .pop_req    (cdbGrant),
        .head_value (cdbValue),
        .head_rob   (cdbRob),
        .count      (count),
        .overflow   (overflow)
    );

    assign cdbRequest = (count != '0);
    // One slot must stay free for the instruction the reservation station
    // has already registered, so only an empty queue, or a single entry that
    // is leaving this cycle, allows another issue.
    assign aluFree = (count == '0) | ((count == QUEUE_CNT_W'(1)) & cdbGrant);

endmodule

// File: tb/tb_alu_cdb_writer.sv
// Self-checking bench for alu_cdb_writer: directed table, hand-written
// corner sequences and a randomized run against a queue-based reference.
module tb_alu_cdb_writer;

    logic               clk = 1'b0;
    logic               globalResetN;
    logic signed [31:0] src1;
    logic signed [31:0] src2;
    logic [3:0]         instrInfo;
    logic [2:0]         instrRob;
    logic               clear;
    logic               validCommit;
    logic               cdbGrant;
    logic               cdbRequest;
    logic [31:0]        cdbValue;
    logic [2:0]         cdbRob;
    logic               aluFree;
    logic               overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] value;
        logic [2:0]  rob;
    } entry_t;

    entry_t model_q[$];
    logic   model_ovf = 1'b0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rob;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    alu_cdb_writer dut (
        .clk          (clk),
        .globalResetN (globalResetN),
        .src1         (src1),
        .src2         (src2),
        .instrInfo    (instrInfo),
        .instrRob     (instrRob),
        .clear        (clear),
        .validCommit  (validCommit),
        .cdbGrant     (cdbGrant),
        .cdbRequest   (cdbRequest),
        .cdbValue     (cdbValue),
        .cdbRob       (cdbRob),
        .aluFree      (aluFree),
        .overflow     (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU written from the op definitions with plain arithmetic.
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic valid);
        logic [63:0] pow2;
        pow2  = 64'd1 << (b % 32);
        valid = 1'b1;
        r     = '0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = 32'({32'b0, a} * pow2);
            4'd6:  r = 32'({32'b0, a} / pow2);
            4'd7:  r = a[31] ? ~(32'({32'b0, ~a} / pow2)) : 32'({32'b0, a} / pow2);
            4'd8:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9:  r = ({32'b0, a} < {32'b0, b}) ? 32'd1 : 32'd0;
            4'd10: r = b;
            default: valid = 1'b0;
        endcase
    endfunction

    task automatic check_model();
        logic        req;
        logic [31:0] ev;
        logic [2:0]  er;
        logic        ef;
        req = (model_q.size() != 0);
        ev  = req ? model_q[0].value : 32'd0;
        er  = req ? model_q[0].rob : 3'd0;
        ef  = (model_q.size() == 0) || (model_q.size() == 1 && cdbGrant);
        check("cdbRequest", 32'(cdbRequest), 32'(req));
        check("cdbValue", cdbValue, ev);
        check("cdbRob", 32'(cdbRob), 32'(er));
        check("aluFree", 32'(aluFree), 32'(ef));
        check("overflow", 32'(overflow), 32'(model_ovf));
    endtask

    // Applies the edge effect of the current inputs to the reference queue.
    task automatic model_update();
        logic [31:0] r;
        logic        v;
        if (clear && validCommit) begin
            model_q.delete();
        end else begin
            if (model_q.size() != 0 && cdbGrant) void'(model_q.pop_front());
            ref_alu(instrInfo, src1, src2, r, v);
            if (v) begin
                if (model_q.size() < 2) model_q.push_back('{value: r, rob: instrRob});
                else model_ovf = 1'b1;
            end
        end
    endtask

    // Called at posedge+1; drives one cycle of inputs and returns at the next posedge+1.
    task automatic drive_cycle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] rob, input logic clr, input logic vc, input logic gnt);
        instrInfo   = op;
        src1        = a;
        src2        = b;
        instrRob    = rob;
        clear       = clr;
        validCommit = vc;
        cdbGrant    = gnt;
        #1;
        check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic bubble(input logic gnt);
        drive_cycle(4'hF, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, gnt);
    endtask

    initial begin
        vecs[0]  = '{"add",   4'd0,  32'd5,         32'hFFFFFFFD, 3'd3, 32'd2};
        vecs[1]  = '{"sra",   4'd7,  32'h80000000,  32'd4,        3'd1, 32'hF8000000};
        vecs[2]  = '{"sltu",  4'd9,  32'd1,         32'hFFFFFFFF, 3'd2, 32'd1};
        vecs[3]  = '{"slt",   4'd8,  32'd1,         32'hFFFFFFFF, 3'd4, 32'd0};
        vecs[4]  = '{"sub",   4'd1,  32'd0,         32'd1,        3'd5, 32'hFFFFFFFF};
        vecs[5]  = '{"and",   4'd2,  32'hF0F0FFFF,  32'h0FF0F00F, 3'd6, 32'h00F0F00F};
        vecs[6]  = '{"or",    4'd3,  32'hF0000000,  32'h0000000F, 3'd7, 32'hF000000F};
        vecs[7]  = '{"xor",   4'd4,  32'hFFFF0000,  32'hFF00FF00, 3'd0, 32'h00FFFF00};
        vecs[8]  = '{"sll",   4'd5,  32'd1,         32'd31,       3'd1, 32'h80000000};
        vecs[9]  = '{"srl",   4'd6,  32'h80000000,  32'd4,        3'd2, 32'h08000000};
        vecs[10] = '{"pass2", 4'd10, 32'hDEADBEEF,  32'h12345000, 3'd3, 32'h12345000};
        vecs[11] = '{"sllamt",4'd5,  32'd1,         32'h00000025, 3'd4, 32'd32};

        globalResetN = 1'b0;
        instrInfo    = 4'hF;
        src1         = '0;
        src2         = '0;
        instrRob     = '0;
        clear        = 1'b0;
        validCommit  = 1'b0;
        cdbGrant     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_request", 32'(cdbRequest), 32'd0);
        check("rst_value", cdbValue, 32'd0);
        check("rst_rob", 32'(cdbRob), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_aluFree", 32'(aluFree), 32'd1);
        globalResetN = 1'b1;

        // Directed op table, granted every cycle: back-to-back throughput.
        foreach (vecs[i]) begin
            drive_cycle(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rob, 1'b0, 1'b0, 1'b1);
            check({"vec_req_", vecs[i].name}, 32'(cdbRequest), 32'd1);
            check({"vec_val_", vecs[i].name}, cdbValue, vecs[i].exp);
            check({"vec_rob_", vecs[i].name}, 32'(cdbRob), 32'(vecs[i].rob));
            $display("vec %s: value %h rob %0d", vecs[i].name, cdbValue, cdbRob);
        end
        bubble(1'b1);
        check("drain_request", 32'(cdbRequest), 32'd0);

        // Backpressure: two queued, then a single grant.
        drive_cycle(4'd0, 32'd1, 32'd1, 3'd1, 1'b0, 1'b0, 1'b0);
        drive_cycle(4'd0, 32'd2, 32'd2, 3'd2, 1'b0, 1'b0, 1'b0);
        check("bp_head_rob", 32'(cdbRob), 32'd1);
        check("bp_full_free", 32'(aluFree), 32'd0);
        bubble(1'b1);
        check("bp_next_rob", 32'(cdbRob), 32'd2);
        cdbGrant = 1'b0;
        #1 check("bp_free_nogrant", 32'(aluFree), 32'd0);
        cdbGrant = 1'b1;
        #1 check("bp_free_grant", 32'(aluFree), 32'd1);
        @(posedge clk);
        model_update();
        #1;
        bubble(1'b0);
        $display("backpressure: request %0d", cdbRequest);

        // Bubble and reserved op never push.
        bubble(1'b0);
        drive_cycle(4'd12, 32'd3, 32'd4, 3'd5, 1'b0, 1'b0, 1'b0);
        check("bubble_request", 32'(cdbRequest), 32'd0);

        // Flush with a valid input present, then clear alone.
        drive_cycle(4'd0, 32'd10, 32'd1, 3'd3, 1'b0, 1'b0, 1'b0);
        drive_cycle(4'd0, 32'd20, 32'd1, 3'd4, 1'b0, 1'b0, 1'b0);
        drive_cycle(4'd0, 32'd30, 32'd1, 3'd5, 1'b1, 1'b1, 1'b1);
        check("flush_request", 32'(cdbRequest), 32'd0);
        drive_cycle(4'd0, 32'd7, 32'd8, 3'd6, 1'b1, 1'b0, 1'b0);
        check("clear_only_req", 32'(cdbRequest), 32'd1);
        check("clear_only_val", cdbValue, 32'd15);
        bubble(1'b1);

        // Overflow is sticky; async reset clears everything mid-cycle.
        drive_cycle(4'd0, 32'd1, 32'd0, 3'd1, 1'b0, 1'b0, 1'b0);
        drive_cycle(4'd0, 32'd2, 32'd0, 3'd2, 1'b0, 1'b0, 1'b0);
        check("pre_ovf", 32'(overflow), 32'd0);
        drive_cycle(4'd0, 32'd3, 32'd0, 3'd3, 1'b0, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_head_rob", 32'(cdbRob), 32'd1);
        bubble(1'b1);
        bubble(1'b1);
        bubble(1'b0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        cdbGrant = 1'b0;
        globalResetN = 1'b0;
        #1;
        check("arst_request", 32'(cdbRequest), 32'd0);
        check("arst_value", cdbValue, 32'd0);
        check("arst_rob", 32'(cdbRob), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_aluFree", 32'(aluFree), 32'd1);
        model_q.delete();
        model_ovf = 1'b0;
        @(posedge clk);
        #1;
        globalResetN = 1'b1;
        drive_cycle(4'd0, 32'd4, 32'd4, 3'd7, 1'b0, 1'b0, 1'b1);
        drive_cycle(4'd0, 32'd5, 32'd5, 3'd6, 1'b0, 1'b0, 1'b1);
        bubble(1'b1);

        // Randomized traffic against the reference queue.
        for (int n = 0; n < 400; n++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic        clr;
            logic        vc;
            op  = 4'($urandom_range(0, 15));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            clr = ($urandom_range(0, 9) == 0);
            vc  = ($urandom_range(0, 2) == 0);
            drive_cycle(op, a, b, 3'($urandom_range(0, 7)), clr, vc, 1'($urandom_range(0, 1)));
        end
        bubble(1'b1);
        bubble(1'b1);
        bubble(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
